// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-client SRAM arbiter.
// Client count and access-type encoding used by the grant logic.
package sram_arb_pkg;

    localparam int NUM_CLIENTS = 2;

    typedef enum logic {
        ACC_RD = 1'b0,
        ACC_WR = 1'b1
    } acc_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-client round-robin grant for one access type.
// KIND selects which requests (reads or writes) this instance serves.
module rr_arb2
    import sram_arb_pkg::*;
#(
    parameter acc_t KIND = ACC_RD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [NUM_CLIENTS-1:0] we,
    output logic [NUM_CLIENTS-1:0] gnt,
    output logic                   win
);

    logic [NUM_CLIENTS-1:0] elig;
    logic                   both;
    logic                   pick;
    logic                   last_q;

    always_comb begin
        elig = (KIND == ACC_WR) ? (req & we) : (req & ~we);
        both = &elig;
        // on contention the client that did not win last time goes next
        pick = both ? ~last_q : elig[1];
        gnt  = '0;
        if (rst_n && (|elig)) begin
            gnt[pick] = 1'b1;
        end
    end

    assign win = pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= pick;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-client arbiter onto a 1R1W SRAM with independent read/write grants.
// Define SRAM_ARB_FWD_EN to forward same-cycle same-address write data.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW = 18,
    parameter int DW = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CLIENTS-1:0]    req,
    input  logic [NUM_CLIENTS-1:0]    we,
    input  logic [NUM_CLIENTS*AW-1:0] addr,
    input  logic [NUM_CLIENTS*DW-1:0] wdata,
    output logic [NUM_CLIENTS-1:0]    gnt,
    output logic [NUM_CLIENTS-1:0]    rvalid,
    output logic [DW-1:0]             rdata,
    output logic [AW-1:0]             sram_raddr,
    input  logic [DW-1:0]             sram_rdata,
    output logic [AW-1:0]             sram_waddr,
    output logic [DW-1:0]             sram_wdata,
    output logic                      sram_wr_enable
);

    logic [NUM_CLIENTS-1:0] rd_gnt;
    logic [NUM_CLIENTS-1:0] wr_gnt;
    logic                   rd_win;
    logic                   wr_win;
    logic                   rd_sel;
    logic                   wr_sel;
    logic [NUM_CLIENTS-1:0] rvalid_q;

    rr_arb2 #(
        .KIND (ACC_RD)
    ) u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .gnt   (rd_gnt),
        .win   (rd_win)
    );

    rr_arb2 #(
        .KIND (ACC_WR)
    ) u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .gnt   (wr_gnt),
        .win   (wr_win)
    );

    // idle ports fall back to client 0
    assign rd_sel = (|rd_gnt) ? rd_win : 1'b0;
    assign wr_sel = (|wr_gnt) ? wr_win : 1'b0;

    assign gnt            = rd_gnt | wr_gnt;
    assign sram_raddr     = rd_sel ? addr[AW +: AW] : addr[0 +: AW];
    assign sram_waddr     = wr_sel ? addr[AW +: AW] : addr[0 +: AW];
    assign sram_wdata     = wr_sel ? wdata[DW +: DW] : wdata[0 +: DW];
    assign sram_wr_enable = |wr_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= rd_gnt;
        end
    end

    assign rvalid = rvalid_q;

`ifdef SRAM_ARB_FWD_EN
    logic          fwd_q;
    logic [DW-1:0] fwd_data_q;
    logic          fwd_hit;

    assign fwd_hit = (|rd_gnt) && (|wr_gnt) && (sram_raddr == sram_waddr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q <= fwd_hit;
            if (fwd_hit) begin
                fwd_data_q <= sram_wdata;
            end
        end
    end

    assign rdata = fwd_q ? fwd_data_q : sram_rdata;
`else
    assign rdata = sram_rdata;
`endif

endmodule
